// File: rtl/binary_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : binary_mac_pkg
// Description : Shared types and helpers for the sequential dot-product MAC.
// Revision    : 1.0 - initial release
// ============================================================================
package binary_mac_pkg;

    // Control states of the MAC sequencer
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result width: full product, plus growth for SETS terms, plus one bit for the c addends
    function automatic int out_width(input int size, input int sets);
        return 2 * size + $clog2(sets) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_lane_sum.sv
`default_nettype none
// ============================================================================
// Module      : mac_lane_sum
// Description : Combinational sum over LANES of (a_j*b_j + c_j), evaluated at
//               OUT_W bits with zero- or sign-extension selected by SIGNED.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_lane_sum #(
    parameter int SIZE   = 6,
    parameter int LANES  = 4,
    parameter int OUT_W  = 17,
    parameter int SIGNED = 0
) (
    input  logic [LANES*SIZE-1:0] a,
    input  logic [LANES*SIZE-1:0] b,
    input  logic [LANES*SIZE-1:0] c,
    output logic [OUT_W-1:0]      sum
);

    localparam logic c_sext = (SIGNED != 0);

    logic [OUT_W-1:0] w_term [LANES];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [SIZE-1:0]   w_a, w_b, w_c;
        logic              w_ea, w_eb, w_ec, w_ep;
        logic [2*SIZE-1:0] w_prod;

        assign w_a  = a[j*SIZE +: SIZE];
        assign w_b  = b[j*SIZE +: SIZE];
        assign w_c  = c[j*SIZE +: SIZE];
        // Extension bits are zero in unsigned mode, the operand MSB in signed mode
        assign w_ea = c_sext & w_a[SIZE-1];
        assign w_eb = c_sext & w_b[SIZE-1];
        assign w_ec = c_sext & w_c[SIZE-1];
        // The low 2*SIZE bits of the extended product are the exact signed/unsigned product
        assign w_prod = {{SIZE{w_ea}}, w_a} * {{SIZE{w_eb}}, w_b};
        assign w_ep   = c_sext & w_prod[2*SIZE-1];
        assign w_term[j] = {{(OUT_W-2*SIZE){w_ep}}, w_prod} + {{(OUT_W-SIZE){w_ec}}, w_c};
    end

    // Add all lane terms; wraps modulo 2^OUT_W
    always_comb begin
        sum = '0;
        for (int j = 0; j < LANES; j++) begin
            sum = sum + w_term[j];
        end
    end

endmodule
`default_nettype wire

// File: rtl/binary_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : binary_mac_seq
// Description : Sequential dot-product MAC, out = sum(a_i*b_i + c_i), LANES
//               elements per beat, valid/ready on both sides, optional chained
//               accumulation onto the previous result.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_mac_seq
    import binary_mac_pkg::*;
#(
    parameter  int SIZE   = 6,
    parameter  int SETS   = 16,
    parameter  int LANES  = 4,
    parameter  int SIGNED = 0,
    localparam int OUT_W  = out_width(SIZE, SETS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_chain,
    input  logic [SETS*SIZE-1:0] a,
    input  logic [SETS*SIZE-1:0] b,
    input  logic [SETS*SIZE-1:0] c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out
);

    localparam int BEATS   = SETS / LANES;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SLICE_W = LANES * SIZE;
    localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(BEATS - 1);

    if (SETS % LANES != 0) begin : g_bad_lanes
        $error("binary_mac_seq: SETS must be a multiple of LANES");
    end

    state_t               r_state, w_next;
    logic [BEAT_W-1:0]    r_beat;
    logic [SETS*SIZE-1:0] r_a, r_b, r_c;
    logic [OUT_W-1:0]     r_acc;
    logic [OUT_W-1:0]     w_lane_sum;
    logic [SLICE_W-1:0]   w_a_slice, w_b_slice, w_c_slice;
    logic                 w_accept;
    logic                 w_last_beat;

    assign w_accept    = in_valid & in_ready;
    assign w_last_beat = (r_beat == c_last_beat);
    assign out         = r_acc;

    // The beat counter picks which LANES-wide group of the stored vector is summed
    assign w_a_slice = r_a[r_beat*SLICE_W +: SLICE_W];
    assign w_b_slice = r_b[r_beat*SLICE_W +: SLICE_W];
    assign w_c_slice = r_c[r_beat*SLICE_W +: SLICE_W];

    mac_lane_sum #(
        .SIZE   (SIZE),
        .LANES  (LANES),
        .OUT_W  (OUT_W),
        .SIGNED (SIGNED)
    ) u_lane_sum (
        .a   (w_a_slice),
        .b   (w_b_slice),
        .c   (w_c_slice),
        .sum (w_lane_sum)
    );

    // Next-state and handshake outputs; DONE can hand over and accept in one cycle
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                if (w_last_beat) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) w_next = in_valid ? RUN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Operands are captured at accept so later input changes cannot disturb the run
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= b;
            r_c <= c;
        end
    end

    // Accumulator and beat counter; out holds its value until the next accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc  <= '0;
            r_beat <= '0;
        end else if (w_accept) begin
            r_acc  <= in_chain ? r_acc : '0;
            r_beat <= '0;
        end else if (r_state == RUN) begin
            r_acc  <= r_acc + w_lane_sum;
            r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        end
    end

endmodule
`default_nettype wire
